sample_source_tx: RTL and testbench

//  Transmit end of the front-end sample interface: drives clk_sample/sample_valid/data into the

---
 rtl/sample_source_tx_pkg.sv | 15 +
 rtl/sample_tx_fifo.sv | 61 ++++++
 rtl/sample_source_tx.sv | 126 ++++++++++++
 tb/tb_sample_source_tx.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/sample_source_tx_pkg.sv
// Shared types and constants for the sample transmit path.
package sample_source_tx_pkg;

    localparam int unsigned ClkDivMin = 16;

    typedef enum logic {
        StIdle = 1'b0,
        StRun  = 1'b1
    } tx_state_e;

    function automatic int unsigned level_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/sample_tx_fifo.sv
// Sample FIFO: flop storage, head read straight from the storage flops, extra level bit for full.
module sample_tx_fifo
    import sample_source_tx_pkg::*;
#(
    parameter int unsigned WIDTH = 3,
    parameter int unsigned DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          wr_req,
    input  logic [WIDTH-1:0]              wr_data,
    input  logic                          rd_req,
    output logic [WIDTH-1:0]              rd_data,
    output logic                          full,
    output logic                          empty,
    output logic [level_width(DEPTH)-1:0] level
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = level_width(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [LW-1:0]    level_q, level_d;
    logic             wr_en, rd_en;

    assign full    = (level_q == LW'(DEPTH));
    assign empty   = (level_q == '0);
    assign level   = level_q;
    assign rd_data = mem_q[rd_ptr_q];

    // Write acceptance uses the current occupancy only; a same-cycle pop does not free a slot.
    assign wr_en = wr_req && !full;
    assign rd_en = rd_req && !empty;

    always_comb begin
        level_d = level_q;
        unique case ({wr_en, rd_en})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (wr_en) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (rd_en) rd_ptr_q <= rd_ptr_q + AW'(1);
            level_q <= level_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q] <= wr_data;
    end

endmodule

// File: rtl/sample_source_tx.sv
// Sample clock generator and FIFO-backed sample launcher.
// Optional SAMPLE_SOURCE_TX_UNDERFLOW_CNT_EN adds a saturating underflow_count output.
module sample_source_tx
    import sample_source_tx_pkg::*;
#(
    parameter int unsigned INPUT_WIDTH = 3,
    parameter int unsigned CLK_DIV     = 16,
    parameter int unsigned FIFO_DEPTH  = 16
) (
    input  logic                               clk,
    input  logic                               reset_n,
    input  logic                               enable,
    input  logic                               wr_valid,
    input  logic [INPUT_WIDTH-1:0]             wr_data,
    output logic                               wr_ready,
    output logic [level_width(FIFO_DEPTH)-1:0] fifo_level,
    output logic                               clk_sample,
    output logic                               sample_valid,
    output logic [INPUT_WIDTH-1:0]             data,
`ifdef SAMPLE_SOURCE_TX_UNDERFLOW_CNT_EN
    output logic [15:0]                        underflow_count,
`endif
    output logic                               underflow
);

    localparam int unsigned PhW  = $clog2(CLK_DIV);
    localparam logic [PhW-1:0] Half = PhW'(CLK_DIV / 2);
    localparam logic [PhW-1:0] Last = PhW'(CLK_DIV - 1);

    tx_state_e             state_q, state_d;
    logic [PhW-1:0]        ph_q, ph_d;
    logic                  launch, pop, clk_sample_d;
    logic                  fifo_full, fifo_empty;
    logic [INPUT_WIDTH-1:0] fifo_head;

    sample_tx_fifo #(
        .WIDTH (INPUT_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .wr_req  (wr_valid),
        .wr_data (wr_data),
        .rd_req  (pop),
        .rd_data (fifo_head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (fifo_level)
    );

    assign wr_ready = !fifo_full;
    assign pop      = launch && !fifo_empty;

    // Launch points are entries into ph==Half; stopping is only allowed there, so every
    // launched sample has already seen its rising edge.
    always_comb begin
        state_d = state_q;
        ph_d    = ph_q;
        launch  = 1'b0;
        unique case (state_q)
            StIdle: begin
                ph_d = '0;
                if (enable) begin
                    state_d = StRun;
                    ph_d    = Half;
                    launch  = 1'b1;
                end
            end
            StRun: begin
                if (ph_q == Half - PhW'(1)) begin
                    if (enable) begin
                        ph_d   = Half;
                        launch = 1'b1;
                    end else begin
                        state_d = StIdle;
                        ph_d    = '0;
                    end
                end else if (ph_q == Last) begin
                    ph_d = '0;
                end else begin
                    ph_d = ph_q + PhW'(1);
                end
            end
            default: begin
                state_d = StIdle;
                ph_d    = '0;
            end
        endcase
        clk_sample_d = (state_d == StRun) && (ph_d < Half);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= StIdle;
            ph_q         <= '0;
            clk_sample   <= 1'b0;
            sample_valid <= 1'b0;
            data         <= '0;
            underflow    <= 1'b0;
        end else begin
            state_q    <= state_d;
            ph_q       <= ph_d;
            clk_sample <= clk_sample_d;
            if (launch) begin
                if (!fifo_empty) begin
                    data         <= fifo_head;
                    sample_valid <= 1'b1;
                end else begin
                    sample_valid <= 1'b0;
                    underflow    <= 1'b1;
                end
            end
        end
    end

`ifdef SAMPLE_SOURCE_TX_UNDERFLOW_CNT_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            underflow_count <= '0;
        end else if (launch && fifo_empty && underflow_count != 16'hFFFF) begin
            underflow_count <= underflow_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_sample_source_tx.sv
// Randomized bench for sample_source_tx against a launch-schedule model and a receiver model.
module tb_sample_source_tx;

    localparam int unsigned W     = 3;
    localparam int unsigned D     = 16;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned H     = D / 2;
    localparam int unsigned LW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          enable;
    logic          wr_valid;
    logic [W-1:0]  wr_data;
    logic          wr_ready;
    logic [LW-1:0] fifo_level;
    logic          clk_sample;
    logic          sample_valid;
    logic [W-1:0]  data;
    logic          underflow;
`ifdef SAMPLE_SOURCE_TX_UNDERFLOW_CNT_EN
    logic [15:0]   underflow_count;
`endif

    sample_source_tx #(
        .INPUT_WIDTH (W),
        .CLK_DIV     (D),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .enable          (enable),
        .wr_valid        (wr_valid),
        .wr_data         (wr_data),
        .wr_ready        (wr_ready),
        .fifo_level      (fifo_level),
        .clk_sample      (clk_sample),
        .sample_valid    (sample_valid),
        .data            (data),
`ifdef SAMPLE_SOURCE_TX_UNDERFLOW_CNT_EN
        .underflow_count (underflow_count),
`endif
        .underflow       (underflow)
    );

    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    // Model: the FIFO is a queue; while running, a launch happens every D cycles counted
    // from the cycle enable was first seen, and stopping is only decided at those points.
    logic [W-1:0] q[$];
    logic [W-1:0] rx_q[$];
    bit           running;
    int           k;
    logic [W-1:0] m_data;
    bit           m_valid, m_uf;
    int           m_cnt;
    bit           prev_clks;

    task automatic model_reset();
        q.delete();
        rx_q.delete();
        running   = 0;
        k         = 0;
        m_data    = '0;
        m_valid   = 0;
        m_uf      = 0;
        m_cnt     = 0;
        prev_clks = 0;
    endtask

    task automatic check_outputs();
        check("clk_sample", 32'(clk_sample), 32'(running && k >= int'(H)));
        check("sample_valid", 32'(sample_valid), 32'(m_valid));
        check("data", 32'(data), 32'(m_data));
        check("underflow", 32'(underflow), 32'(m_uf));
        check("fifo_level", 32'(fifo_level), 32'(q.size()));
`ifdef SAMPLE_SOURCE_TX_UNDERFLOW_CNT_EN
        check("underflow_count", 32'(underflow_count), 32'(m_cnt));
`endif
    endtask

    // One clock: inputs were set before the edge; check state after it.
    task automatic step();
        bit full_pre;
        bit launch;
        logic [W-1:0] head;
        full_pre = (q.size() == DEPTH);
        check("wr_ready", 32'(wr_ready), 32'(!full_pre));
        @(posedge clk);
        #1;
        launch = 0;
        if (!running) begin
            if (enable) begin
                running = 1;
                k       = 0;
                launch  = 1;
            end
        end else begin
            k++;
            if (k == int'(D)) begin
                if (enable) begin
                    k      = 0;
                    launch = 1;
                end else begin
                    running = 0;
                    k       = 0;
                end
            end
        end
        if (launch) begin
            if (q.size() > 0) begin
                head    = q.pop_front();
                m_data  = head;
                m_valid = 1;
            end else begin
                m_valid = 0;
                m_uf    = 1;
                if (m_cnt < 16'hFFFF) m_cnt++;
            end
        end
        if (wr_valid && !full_pre) begin
            q.push_back(wr_data);
            rx_q.push_back(wr_data);
        end
        check_outputs();
        // Receiver: capture at each clk_sample rise, compare against the written order.
        if (clk_sample && !prev_clks && sample_valid) begin
            if (rx_q.size() == 0) check("rx_extra", 32'(data), 32'hFFFF_FFFF);
            else check("rx_data", 32'(data), 32'(rx_q.pop_front()));
        end
        prev_clks = clk_sample;
    endtask

    task automatic check_reset_values();
        check("rst_clk_sample", 32'(clk_sample), 32'd0);
        check("rst_sample_valid", 32'(sample_valid), 32'd0);
        check("rst_data", 32'(data), 32'd0);
        check("rst_underflow", 32'(underflow), 32'd0);
        check("rst_fifo_level", 32'(fifo_level), 32'd0);
        check("rst_wr_ready", 32'(wr_ready), 32'd1);
    endtask

    // Assert reset off-edge, check asynchronous clearing, release after the edge.
    task automatic do_reset();
        reset_n = 1'b0;
        #1;
        check_reset_values();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    int rate;
    int guard;

    initial begin
        reset_n  = 1'b1;
        enable   = 1'b0;
        wr_valid = 1'b0;
        wr_data  = '0;
        model_reset();
        #2;
        do_reset();

        // Directed: four samples then run, followed by underflow periods.
        for (int i = 1; i <= 4; i++) begin
            wr_valid = 1'b1;
            wr_data  = W'(i);
            step();
        end
        wr_valid = 1'b0;
        enable   = 1'b1;
        repeat (7 * D) step();

        // Fill past full while stopped.
        enable = 1'b0;
        repeat (2 * D) step();
        for (int i = 0; i < int'(DEPTH) + 3; i++) begin
            wr_valid = 1'b1;
            wr_data  = W'($urandom);
            step();
        end
        wr_valid = 1'b0;
        enable   = 1'b1;
        repeat (2 * D) step();

        // Drop enable at ph=3 of the high phase, idle a while, re-enable.
        guard = 0;
        while (!(running && k == int'(D - H + 3)) && guard < 4 * int'(D)) begin
            step();
            guard++;
        end
        check("ph3_reached", 32'(running && k == int'(D - H + 3)), 32'd1);
        enable = 1'b0;
        repeat (2 * D) step();
        enable = 1'b1;
        repeat (3 * D) step();

        // Async reset mid-period with a loaded FIFO.
        for (int i = 0; i < 5; i++) begin
            wr_valid = 1'b1;
            wr_data  = W'($urandom);
            step();
        end
        wr_valid = 1'b0;
        repeat (5) step();
        #3;
        do_reset();
        enable = 1'b0;
        repeat (D) step();

        // Random playback.
        rate = 6;
        for (int c = 0; c < 16000; c++) begin
            if (c % 500 == 0) rate = int'($urandom_range(2, 12));
            if ($urandom_range(0, 299) == 0) enable = ~enable;
            wr_valid = ($urandom_range(0, 99) < rate);
            wr_data  = W'($urandom);
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
